// File: rtl/silife_sync_master.sv
// Edge-sync link master: sync clock and active-window sequencer.
// Optional drain watchdog: define SILIFE_SYNC_TIMEOUT_EN.
module silife_sync_master #(
  parameter int WIDTH       = 32,
  parameter int HALF_PERIOD = 4,
  parameter int SETTLE      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_peer_busy,
  output logic o_sync_clk_syn,
  output logic o_sync_active_syn,
  output logic o_busy,
  output logic o_done,
  output logic o_error
);

  localparam int BW   = $clog2(WIDTH + 1) + 1;
  localparam int PM0  = (HALF_PERIOD > SETTLE) ? HALF_PERIOD : SETTLE;
  localparam int PMAX = (PM0 > 3) ? PM0 : 3;
  localparam int PW   = $clog2(PMAX);

  localparam logic [PW-1:0] HP_LD = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] ST_LD = PW'(SETTLE - 1);
  localparam logic [PW-1:0] DR_LD = PW'(2);
  localparam logic [BW-1:0] NBITS = BW'(WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOW,
    ST_HIGH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            sclk_q, act_q, busy_q, done_q;

`ifdef SILIFE_SYNC_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
`ifdef SILIFE_SYNC_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SETTLE;
          phase_d = ST_LD;
          bit_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (phase_q == '0) begin
          state_d = ST_LOW;
          phase_d = HP_LD;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      ST_LOW: begin
        if (phase_q == '0) begin
          state_d = ST_HIGH;
          phase_d = HP_LD;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      ST_HIGH: begin
        if (phase_q == '0) begin
          bit_d = bit_q + BW'(1);
          if (bit_d == NBITS) begin
            state_d = ST_DRAIN;
            phase_d = DR_LD;
`ifdef SILIFE_SYNC_TIMEOUT_EN
            wd_d    = '0;
`endif
          end else begin
            state_d = ST_LOW;
            phase_d = HP_LD;
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      ST_DRAIN: begin
`ifdef SILIFE_SYNC_TIMEOUT_EN
        wd_d = i_peer_busy ? wd_q + 8'd1 : 8'd0;
        // 256th consecutive busy cycle gives up on the peers
        if (i_peer_busy && wd_q == 8'hFF) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else
`endif
        if (phase_q != '0) begin
          phase_d = phase_q - PW'(1);
        end else if (!i_peer_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end

  // Outputs are registered copies of the state decode: glitch-free nets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= 1'b1;
      act_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sclk_q <= (state_q != ST_LOW);
      act_q  <= (state_q == ST_SETTLE) || (state_q == ST_LOW) ||
                (state_q == ST_HIGH) || (state_q == ST_DRAIN);
      busy_q <= (state_q != ST_IDLE);
      done_q <= (state_q == ST_DONE);
    end
  end

`ifdef SILIFE_SYNC_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_sync_clk_syn    = sclk_q;
  assign o_sync_active_syn = act_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;

endmodule
